// File: rtl/hps_spectrum_source_pkg.sv
// hps_spectrum_source_pkg: shared widths, FSM encoding and pipeline latency
// for the harmonic product spectrum source and its verification environment.
package hps_spectrum_source_pkg;
    localparam int MAG_IN_WIDTH_DEFAULT  = 32;
    localparam int K_WIDTH_DEFAULT       = 11;
    localparam int MAG_OUT_WIDTH_DEFAULT = 3 * MAG_IN_WIDTH_DEFAULT;
    localparam int PIPE_LATENCY          = 3;
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/hps_spectrum_source_spectrum_ram.sv
// spectrum_ram: simple dual-port RAM, one write port and one registered read port.
module spectrum_ram #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WIDTH-1:0]      read_data
);
    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (write_en)
            mem[write_addr] <= write_data;
        read_data <= mem[read_addr];
    end
endmodule

// File: rtl/hps_spectrum_source.sv
// hps_spectrum_source: buffers one FFT magnitude frame, then replays it as
// |X[k]|*|X[2k]|*|X[3k]| for k = 0..N-1 through a 3-cycle pipeline.
module hps_spectrum_source
    import hps_spectrum_source_pkg::*;
#(
    parameter int  MAG_IN_WIDTH  = MAG_IN_WIDTH_DEFAULT,
    parameter int  K_WIDTH       = K_WIDTH_DEFAULT,
    localparam int MAG_OUT_WIDTH = 3 * MAG_IN_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     s_valid,
    input  logic [MAG_IN_WIDTH-1:0]  s_mag,
    input  logic [K_WIDTH-1:0]       s_k,
    input  logic                     s_last,
    output logic                     frame_start,
    output logic                     data_valid,
    output logic [MAG_OUT_WIDTH-1:0] data_out,
    output logic [K_WIDTH-1:0]       k_out,
    output logic                     busy,
    output logic                     overrun
);
    localparam int N  = 2**K_WIDTH;
    localparam int HW = K_WIDTH + 2;
    localparam int PW = 2 * MAG_IN_WIDTH;

    state_t                  state, state_next;
    logic [K_WIDTH-1:0]      rk;
    logic [1:0]              drain_cnt;
    logic                    write_en;
    logic [HW-1:0]           rk_ext, h2, h3;
    logic                    ok2, ok3;
    logic [MAG_IN_WIDTH-1:0] rd_a, rd_b, rd_c;
    logic                    v1, ok2_1, ok3_1, v2;
    logic [K_WIDTH-1:0]      k1, k2;
    logic [PW-1:0]           p1;
    logic [MAG_IN_WIDTH-1:0] c2;

    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= FILL;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        busy        = state != FILL;
        frame_start = state == READ && rk == '0;
        write_en    = s_valid && state == FILL;
        unique case (state)
            FILL:    if (s_valid && s_last) state_next = READ;
            READ:    if (rk == '1) state_next = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        rk        <= (!reset_n || state != READ) ? '0 : rk + 1'b1;
        drain_cnt <= (!reset_n || state != DRAIN) ? '0 : drain_cnt + 2'd1;
    end

    // Harmonic indices are widened so 2k/3k beyond the frame are detected, not wrapped.
    always_comb begin
        rk_ext = HW'(rk);
        h2     = rk_ext << 1;
        h3     = h2 + rk_ext;
        ok2    = h2 <= HW'(N - 1);
        ok3    = h3 <= HW'(N - 1);
    end

    spectrum_ram #(.WIDTH(MAG_IN_WIDTH), .ADDR_WIDTH(K_WIDTH)) ram_a (
        .clock(clock), .write_en(write_en), .write_addr(s_k), .write_data(s_mag),
        .read_addr(rk), .read_data(rd_a)
    );

    spectrum_ram #(.WIDTH(MAG_IN_WIDTH), .ADDR_WIDTH(K_WIDTH)) ram_b (
        .clock(clock), .write_en(write_en), .write_addr(s_k), .write_data(s_mag),
        .read_addr(h2[K_WIDTH-1:0]), .read_data(rd_b)
    );

    spectrum_ram #(.WIDTH(MAG_IN_WIDTH), .ADDR_WIDTH(K_WIDTH)) ram_c (
        .clock(clock), .write_en(write_en), .write_addr(s_k), .write_data(s_mag),
        .read_addr(h3[K_WIDTH-1:0]), .read_data(rd_c)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v1         <= 1'b0;
            ok2_1      <= 1'b0;
            ok3_1      <= 1'b0;
            v2         <= 1'b0;
            data_valid <= 1'b0;
            k_out      <= '0;
            data_out   <= '0;
            overrun    <= 1'b0;
        end else begin
            v1         <= state == READ;
            ok2_1      <= ok2;
            ok3_1      <= ok3;
            v2         <= v1;
            data_valid <= v2;
            k_out      <= v2 ? k2 : '0;
            data_out   <= v2 ? MAG_OUT_WIDTH'(p1) * MAG_OUT_WIDTH'(c2) : '0;
            overrun    <= s_valid && state != FILL;
        end
    end

    always_ff @(posedge clock) begin
        k1 <= rk;
        k2 <= k1;
        p1 <= PW'(rd_a) * PW'(ok2_1 ? rd_b : '0);
        c2 <= ok3_1 ? rd_c : '0;
    end
endmodule

// File: tb/tb_hps_spectrum_source.sv
// tb_hps_spectrum_source: randomized frames checked against an array-based
// harmonic product model, plus literal spot checks and reset/overrun cases.
module tb_hps_spectrum_source;
    import hps_spectrum_source_pkg::*;

    localparam int MW = 8;
    localparam int KW = 3;
    localparam int N  = 8;
    localparam int OW = 3 * MW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [MW-1:0] s_mag = '0;
    logic [KW-1:0] s_k = '0;
    logic          s_last = 1'b0;
    logic          frame_start, data_valid, busy, overrun;
    logic [OW-1:0] data_out;
    logic [KW-1:0] k_out;

    hps_spectrum_source #(.MAG_IN_WIDTH(MW), .K_WIDTH(KW)) dut (
        .clock(clock), .reset_n(reset_n), .s_valid(s_valid), .s_mag(s_mag),
        .s_k(s_k), .s_last(s_last), .frame_start(frame_start),
        .data_valid(data_valid), .data_out(data_out), .k_out(k_out),
        .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int              n_checks = 0;
    int              n_fail = 0;
    logic [MW-1:0]   mem [N];
    logic [MW-1:0]   frame_mag [N];
    int              frame_ord [N];
    longint unsigned exp_q [$];
    longint unsigned got [N];
    int              cyc = 0;
    int              fs_at = -100;
    int              win_start = -100;
    int              ov_cnt = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint unsigned hps(input int k);
        longint unsigned a = mem[k];
        longint unsigned b = (2 * k < N) ? mem[2 * k] : 0;
        longint unsigned c = (3 * k < N) ? mem[3 * k] : 0;
        return a * b * c;
    endfunction

    always @(negedge clock) begin
        longint unsigned e;
        bit exp_dv;
        cyc++;
        exp_dv = cyc >= win_start && cyc < win_start + N;
        check("frame_start", frame_start, cyc == fs_at);
        check("data_valid", data_valid, exp_dv);
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got k_out %0d, expected no beat", k_out);
            end else begin
                e = exp_q.pop_front();
                check("data_out", data_out, e);
            end
            check("k_out", k_out, longint'(cyc - win_start));
            got[k_out] = data_out;
        end else
            check("k_out_idle", k_out, 0);
        if (overrun) ov_cnt++;
    end

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clock); #1;
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            @(posedge clock); #1;
            s_valid = 1'b1;
            s_k     = KW'(frame_ord[i]);
            s_mag   = frame_mag[frame_ord[i]];
            s_last  = i == N - 1;
            mem[frame_ord[i]] = frame_mag[frame_ord[i]];
            if (i == N - 1) begin
                fs_at     = cyc + 2;
                win_start = fs_at + PIPE_LATENCY;
            end
        end
        @(posedge clock); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int k = 0; k < N; k++) exp_q.push_back(hps(k));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge clock); #1;
        end
        check("busy_timeout", busy, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic random_frame();
        int j, t;
        for (int k = 0; k < N; k++) begin
            frame_mag[k] = MW'($urandom_range(0, 255));
            frame_ord[k] = k;
        end
        for (int k = N - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = frame_ord[k];
            frame_ord[k] = frame_ord[j];
            frame_ord[j] = t;
        end
    endtask

    initial begin
        longint unsigned lit [N] = '{1, 24, 105, 0, 0, 0, 0, 0};
        int ov_before;
        bit hit;
        repeat (3) @(posedge clock);
        #1;
        check("reset_data_valid", data_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_data_out", data_out, 0);
        reset_n = 1'b1;

        for (int k = 0; k < N; k++) begin
            frame_mag[k] = MW'(k + 1);
            frame_ord[k] = k;
        end
        send_frame(1'b0);
        wait_idle();
        for (int k = 0; k < N; k++) check("in_order_lit", got[k], lit[k]);

        for (int k = 0; k < N; k++) frame_ord[k] = N - 1 - k;
        got = '{default: 0};
        send_frame(1'b0);
        wait_idle();
        for (int k = 0; k < N; k++) check("reverse_lit", got[k], lit[k]);

        random_frame();
        send_frame(1'b1);
        ov_before = ov_cnt;
        s_valid = 1'b1; s_k = 3'd0; s_mag = 8'd99;
        @(posedge clock); #1;
        s_valid = 1'b0;
        check("busy_in_read", busy, 1);
        @(posedge clock); #1;
        s_valid = 1'b1; s_k = 3'd5; s_mag = 8'd77;
        @(posedge clock); #1;
        s_valid = 1'b0;
        wait_idle();
        check("overrun_count", longint'(ov_cnt - ov_before), 2);
        random_frame();
        send_frame(1'b1);
        wait_idle();

        for (int k = 0; k < N; k++) begin
            frame_mag[k] = 8'd255;
            frame_ord[k] = k;
        end
        send_frame(1'b0);
        wait_idle();
        check("full_width_k0", got[0], 16581375);
        check("clamped_k3", got[3], 0);

        repeat (4) begin
            random_frame();
            send_frame(1'b1);
            wait_idle();
        end

        random_frame();
        send_frame(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clock); #1;
            hit = data_valid && k_out == 3'd4;
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_k4: got no k_out=4 beat, expected one within 50 cycles");
        end
        reset_n = 1'b0;
        @(posedge clock); #1;
        exp_q.delete();
        fs_at     = -100;
        win_start = -100;
        reset_n   = 1'b1;
        check("rst_mid_valid", data_valid, 0);
        check("rst_mid_k_out", k_out, 0);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(posedge clock);
        #1;
        random_frame();
        send_frame(1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
